// File: rtl/wb_initiator_pkg.sv
// rtl/wb_initiator_pkg.sv - shared types and constants for the Wishbone initiator
//
// Holds the initiator state encoding, the timeout counter width and the
// project-select harness register addresses used by benches and the debug bridge.

package wb_initiator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wbi_state_e;

    localparam int WBI_CNT_W = 16;

    localparam logic [31:0] HARNESS_ACTIVE_ADR = 32'h3000_0000;
    localparam logic [31:0] HARNESS_OEB0_ADR   = 32'h3000_0004;
    localparam logic [31:0] HARNESS_OEB1_ADR   = 32'h3000_0008;
    localparam logic [31:0] HARNESS_WS2812_ADR = 32'h3000_0100;
    localparam logic [31:0] HARNESS_7SEG_ADR   = 32'h3000_0200;
    localparam logic [31:0] HARNESS_FREQ_ADR   = 32'h3000_0400;
    localparam logic [31:0] HARNESS_WATCH_ADR  = 32'h3000_0500;

endpackage

// File: rtl/wb_timeout_counter.sv
// rtl/wb_timeout_counter.sv - saturating bus-cycle timeout counter
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   clear           zero the count (takes priority over enable)
//   enable          count one more waiting cycle at this edge
//   expired         the count reaches LIMIT at the coming edge if enabled

module wb_timeout_counter #(
    parameter int CNT_W = 16,
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds the number of waiting edges already seen; the edge that
    // would make it LIMIT is the expiring one.
    assign expired = (count_q >= LAST);

endmodule

// File: rtl/wishbone_initiator.sv
// rtl/wishbone_initiator.sv - single-outstanding Wishbone classic-cycle initiator
//
// Optional feature macro: WB_INITIATOR_TIMEOUT_EN (timeout counter and abort path).
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_we/cmd_sel/cmd_adr/cmd_dat command fields
//   rsp_valid/rsp_ready            response handshake
//   rsp_dat/rsp_err                read data (0 for writes/errors), timeout flag
//   busy                           high while a cycle or response is pending
//   wbm_*                          Wishbone master port

module wishbone_initiator
    import wb_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [3:0]  cmd_sel,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        busy,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    wbi_state_e  state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;

    logic cmd_fire;
    logic bus_ack;
    logic timeout_hit;

    assign cmd_fire = (state_q == ST_IDLE) && cmd_valid;
    // ack only counts while a cycle is in flight; late or stale acks fall through
    assign bus_ack  = (state_q == ST_BUS) && wbm_ack_i;

`ifdef WB_INITIATOR_TIMEOUT_EN
    logic expired;
    logic err_q, err_d;

    wb_timeout_counter #(
        .CNT_W (WBI_CNT_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (cmd_fire),
        .enable  ((state_q == ST_BUS) && !wbm_ack_i),
        .expired (expired)
    );

    // ack on the expiring edge wins
    assign timeout_hit = (state_q == ST_BUS) && !wbm_ack_i && expired;

    always_comb begin
        err_d = err_q;
        if (bus_ack) begin
            err_d = 1'b0;
        end else if (timeout_hit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign rsp_err = err_q;
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES > 0);
    assign timeout_hit    = 1'b0;
    assign rsp_err        = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid)               state_d = ST_BUS;
            ST_BUS:  if (bus_ack || timeout_hit)  state_d = ST_RESP;
            ST_RESP: if (rsp_ready)               state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
    end

    // outputs decoded from state
    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
    end

    // bus and response datapath
    always_comb begin
        cyc_d     = cyc_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rsp_dat_d = rsp_dat_q;
        if (cmd_fire) begin
            cyc_d = 1'b1;
            we_d  = cmd_we;
            sel_d = cmd_sel;
            adr_d = cmd_adr;
            dat_d = cmd_dat;
        end else if (bus_ack) begin
            cyc_d     = 1'b0;
            rsp_dat_d = we_q ? 32'h0 : wbm_dat_i;
        end else if (timeout_hit) begin
            cyc_d     = 1'b0;
            rsp_dat_d = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= 4'h0;
            adr_q     <= 32'h0;
            dat_q     <= 32'h0;
            rsp_dat_q <= 32'h0;
        end else begin
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            rsp_dat_q <= rsp_dat_d;
        end
    end

    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign rsp_dat   = rsp_dat_q;

endmodule
